// File: rtl/mul_seq_pkg.sv
// mul_seq_pkg: shared state encoding and sizing helpers for the sequential multiplier.
package mul_seq_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   localparam int DEF_WIDTH = 6;
   localparam int CNT_W = $clog2(DEF_WIDTH);
   function automatic int cnt_w(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction
endpackage

// File: rtl/mul_step.sv
// mul_step: one shift-add partial-product iteration.
module mul_step #(
   parameter int WIDTH  = 6,
   parameter int PWIDTH = 2*WIDTH
) (
   input  logic [PWIDTH-1:0] acc,
   input  logic [PWIDTH-1:0] mcand,
   input  logic [WIDTH-1:0]  mplier,
   output logic [PWIDTH-1:0] acc_next,
   output logic [PWIDTH-1:0] mcand_next,
   output logic [WIDTH-1:0]  mplier_next
);
   always_comb begin
      acc_next    = mplier[0] ? acc + mcand : acc;
      mcand_next  = mcand << 1;
      mplier_next = mplier >> 1;
   end
endmodule

// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: shift-add multiplier sequencer, one partial product per clock,
// fixed WIDTH-cycle latency, valid/ready on both operand and product sides.
module mul_seq_ctrl import mul_seq_pkg::*; #(
   parameter int WIDTH  = 6,
   parameter int PWIDTH = 2*WIDTH
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  a,
   input  logic [WIDTH-1:0]  b,
   input  logic              abort,
   output logic              busy,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PWIDTH-1:0] product
);
   localparam int CW = cnt_w(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH-1);

   state_t            state;
   logic [PWIDTH-1:0] acc, mcand, acc_next, mcand_next;
   logic [WIDTH-1:0]  mplier, mplier_next;
   logic [CW-1:0]     count;

   mul_step #(.WIDTH(WIDTH), .PWIDTH(PWIDTH)) u_step (
      .acc(acc), .mcand(mcand), .mplier(mplier),
      .acc_next(acc_next), .mcand_next(mcand_next), .mplier_next(mplier_next)
   );

   // rst gating keeps in_ready low while reset is held, even though state is already IDLE
   assign in_ready  = (state == IDLE) && !rst;
   assign out_valid = (state == DONE);
   assign busy      = (state == RUN) || (state == DONE);
   assign product   = acc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         count  <= '0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               mcand  <= PWIDTH'(a);
               mplier <= b;
               acc    <= '0;
               count  <= '0;
               state  <= RUN;
            end
            RUN: if (abort) state <= IDLE;
            else begin
               acc    <= acc_next;
               mcand  <= mcand_next;
               mplier <= mplier_next;
               count  <= count + 1'b1;
               if (count == LAST) state <= DONE;
            end
            DONE: if (abort || out_ready) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule
